// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet datapath blocks: default payload width and
// the width helper used for counters and occupancy ports.
package lenet_pkg;

  localparam int unsigned LENET_DATA_WIDTH = 8;

  // Bits needed to hold any value 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid flag plus a payload register. The payload is only
// written when a valid beat arrives, so bubbles never toggle the data flops.
module dff_pipe_stage #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_capture;

  assign w_capture = i_load & i_valid;

  // Valid flag: async reset, sync clear has priority over a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  // Payload: clearable variant, or reset-free flops when RST_DATA is off.
  generate
    if (RST_DATA) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (i_clr) begin
          r_data <= '0;
        end else if (w_capture) begin
          r_data <= i_data;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (w_capture) begin
          r_data <= i_data;
        end
      end
    end
  endgenerate

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage valid/ready register pipeline used as a retiming element between
// LeNet datapath blocks; bubbles collapse under backpressure.
module dff_pipe
  import lenet_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LENET_DATA_WIDTH,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned DEPTH      = 2,
  parameter bit          RST_DATA   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [cnt_width(DEPTH)-1:0]    occupancy
);

  localparam int unsigned W     = CHANNELS * DATA_WIDTH;
  localparam int unsigned OCC_W = cnt_width(DEPTH);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipe: DEPTH must be at least 1");
    end
  endgenerate

  logic [DEPTH-1:0]        w_valid;
  logic [DEPTH-1:0][W-1:0] w_data;
  logic [DEPTH-1:0]        w_ready;
  logic [DEPTH-1:0]        w_src_valid;
  logic [DEPTH-1:0][W-1:0] w_src_data;
  logic                    w_accept;
  logic [OCC_W-1:0]        w_occ;

  assign in_ready = w_ready[0] & ~flush & ~rst;
  assign w_accept = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Stage gi can advance unless it and every stage after it is full and
      // the consumer is stalled; flattened so there is no combinational loop.
      assign w_ready[gi] = out_ready | ~(&w_valid[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        assign w_src_valid[gi] = w_accept;
        assign w_src_data[gi]  = in_data;
      end else begin : g_body
        assign w_src_valid[gi] = w_valid[gi-1];
        assign w_src_data[gi]  = w_data[gi-1];
      end

      dff_pipe_stage #(
        .WIDTH    (W),
        .RST_DATA (RST_DATA)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_load  (w_ready[gi]),
        .i_valid (w_src_valid[gi]),
        .i_data  (w_src_data[gi]),
        .o_valid (w_valid[gi]),
        .o_data  (w_data[gi])
      );
    end
  endgenerate

  // Occupancy is the popcount of the registered valid flags.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(w_valid[i]);
    end
  end

  assign occupancy = w_occ;
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];

endmodule
